// File: rtl/wb_sequencer_if.sv
// ============================================================================
// Module      : wb_sequencer_if
// Description : Issue, data-memory handshake and register-file write port
//               bundle for the write-back sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_sequencer_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] result_src;
    logic       reg_write;
    logic [4:0] rd;
    logic       mem_req;
    logic       mem_rsp_valid;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic [4:0] rf_waddr;
    logic       err;

    // Core / environment side: issues instructions and returns load data.
    modport master (
        output issue_valid,
        output result_src,
        output reg_write,
        output rd,
        output mem_rsp_valid,
        input  issue_ready,
        input  mem_req,
        input  wb_sel,
        input  rf_we,
        input  rf_waddr,
        input  err
    );

    // Sequencer side.
    modport slave (
        input  issue_valid,
        input  result_src,
        input  reg_write,
        input  rd,
        input  mem_rsp_valid,
        output issue_ready,
        output mem_req,
        output wb_sel,
        output rf_we,
        output rf_waddr,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/wb_sequencer.sv
// ============================================================================
// Module      : wb_sequencer
// Description : Write-back stage sequencer: drives the 3-to-1 write-back mux
//               select and register-file write port, stalls issue on loads,
//               enforces a memory-response timeout and flags bad sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  wire              clk,
    input  wire              rst_n,
    wb_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WAIT_MEM = 2'd2
    } state_t;

    localparam logic [1:0]       c_SRC_ALU  = 2'b00;
    localparam logic [1:0]       c_SRC_MEM  = 2'b01;
    localparam logic [1:0]       c_SRC_RSVD = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [1:0]       r_src;
    logic [4:0]       r_rd;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [1:0]       w_src_nxt;
    logic [4:0]       w_rd_nxt;
    logic             w_we_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_ready;
    logic             w_accept;
    logic             w_mem_req;
    logic [1:0]       w_wb_sel;
    logic             w_rf_we;
    logic [4:0]       w_rf_waddr;
    logic             w_err;

    // Ready depends on state only, so accept never loops back on itself.
    assign w_ready  = (r_state != S_WAIT_MEM);
    assign w_accept = bus.issue_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_src   <= 2'b00;
            r_rd    <= 5'd0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_rd    <= w_rd_nxt;
            r_we    <= w_we_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_rd_nxt    = r_rd;
        w_we_nxt    = r_we;
        w_cnt_nxt   = r_cnt;
        w_mem_req   = 1'b0;
        w_wb_sel    = c_SRC_ALU;
        w_rf_we     = 1'b0;
        w_rf_waddr  = 5'd0;
        w_err       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end

            S_WRITE: begin
                w_wb_sel    = (r_src == c_SRC_RSVD) ? c_SRC_ALU : r_src;
                w_rf_waddr  = r_rd;
                w_rf_we     = r_we && (r_rd != 5'd0) && (r_src != c_SRC_RSVD);
                w_err       = (r_src == c_SRC_RSVD);
                w_state_nxt = S_IDLE;
            end

            S_WAIT_MEM: begin
                w_wb_sel   = c_SRC_MEM;
                w_rf_waddr = r_rd;
                w_mem_req  = (r_cnt == '0);
                // A response in the request cycle itself is a legal zero-latency load.
                if (bus.mem_rsp_valid) begin
                    w_rf_we     = r_we && (r_rd != 5'd0);
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Accepting from IDLE or WRITE gives back-to-back issue with no bubble.
        if (w_accept) begin
            w_src_nxt   = bus.result_src;
            w_rd_nxt    = bus.rd;
            w_we_nxt    = bus.reg_write;
            w_cnt_nxt   = '0;
            w_state_nxt = (bus.result_src == c_SRC_MEM) ? S_WAIT_MEM : S_WRITE;
        end
    end

    assign bus.issue_ready = w_ready;
    assign bus.mem_req     = w_mem_req;
    assign bus.wb_sel      = w_wb_sel;
    assign bus.rf_we       = w_rf_we;
    assign bus.rf_waddr    = w_rf_waddr;
    assign bus.err         = w_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_sequencer.sv
// ============================================================================
// Module      : tb_wb_sequencer
// Description : Self-checking bench for wb_sequencer: directed scenarios plus
//               randomized traffic against an instruction-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sequencer;

    localparam int TO = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_sequencer_if bus ();

    wb_sequencer #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently owning the write-back stage
    // and how many cycles it has been there.
    logic       m_active;
    logic       m_load;
    logic [1:0] m_src;
    logic [4:0] m_rd;
    logic       m_we;
    int         m_age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_load   <= 1'b0;
            m_src    <= 2'b00;
            m_rd     <= 5'd0;
            m_we     <= 1'b0;
            m_age    <= 0;
        end else if (m_active && m_load) begin
            if (bus.mem_rsp_valid || m_age == TO) m_active <= 1'b0;
            else                                  m_age    <= m_age + 1;
        end else if (bus.issue_valid) begin
            m_active <= 1'b1;
            m_load   <= (bus.result_src == 2'd1);
            m_src    <= bus.result_src;
            m_rd     <= bus.rd;
            m_we     <= bus.reg_write;
            m_age    <= 1;
        end else begin
            m_active <= 1'b0;
        end
    end

    logic       e_ready, e_req, e_we, e_err;
    logic [1:0] e_sel;
    logic [4:0] e_addr;

    always_comb begin
        e_ready = !(m_active && m_load);
        e_req   = 1'b0;
        e_we    = 1'b0;
        e_err   = 1'b0;
        e_sel   = 2'd0;
        e_addr  = 5'd0;
        if (m_active && !m_load) begin
            e_sel  = (m_src == 2'd3) ? 2'd0 : m_src;
            e_addr = m_rd;
            e_we   = m_we && (m_rd != 5'd0) && (m_src != 2'd3);
            e_err  = (m_src == 2'd3);
        end else if (m_active) begin
            e_sel  = 2'd1;
            e_addr = m_rd;
            e_req  = (m_age == 1);
            if (bus.mem_rsp_valid) e_we  = m_we && (m_rd != 5'd0);
            else if (m_age == TO)  e_err = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        chk("issue_ready", 32'(bus.issue_ready), 32'(e_ready));
        chk("mem_req",     32'(bus.mem_req),     32'(e_req));
        chk("wb_sel",      32'(bus.wb_sel),      32'(e_sel));
        chk("rf_we",       32'(bus.rf_we),       32'(e_we));
        chk("rf_waddr",    32'(bus.rf_waddr),    32'(e_addr));
        chk("err",         32'(bus.err),         32'(e_err));
    end

    task automatic cyc(input logic v, input logic [1:0] s, input logic w,
                       input logic [4:0] r, input logic rsp);
        @(negedge clk);
        bus.issue_valid   = v;
        bus.result_src    = s;
        bus.reg_write     = w;
        bus.rd            = r;
        bus.mem_rsp_valid = rsp;
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        int errs;
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.result_src    = 2'd0;
        bus.reg_write     = 1'b0;
        bus.rd            = 5'd0;
        bus.mem_rsp_valid = 1'b0;

        @(negedge clk); #3;
        chk("rst ready", 32'(bus.issue_ready), 32'd1);
        chk("rst we",    32'(bus.rf_we),       32'd0);
        chk("rst sel",   32'(bus.wb_sel),      32'd0);
        rst_n = 1'b1;

        // ALU write rd=5
        cyc(1, 2'd0, 1, 5'd5, 0);
        idle(); #3;
        chk("alu we",   32'(bus.rf_we),    32'd1);
        chk("alu addr", 32'(bus.rf_waddr), 32'd5);
        idle(); #3;
        chk("alu idle we", 32'(bus.rf_we), 32'd0);

        // Back-to-back PC+4 then ALU
        cyc(1, 2'd2, 1, 5'd1, 0);
        cyc(1, 2'd0, 1, 5'd2, 0); #3;
        chk("b2b sel0",  32'(bus.wb_sel),      32'd2);
        chk("b2b addr0", 32'(bus.rf_waddr),    32'd1);
        chk("b2b rdy0",  32'(bus.issue_ready), 32'd1);
        idle(); #3;
        chk("b2b sel1",  32'(bus.wb_sel),   32'd0);
        chk("b2b addr1", 32'(bus.rf_waddr), 32'd2);
        chk("b2b we1",   32'(bus.rf_we),    32'd1);

        // Load rd=7, response in 4th wait cycle
        cyc(1, 2'd1, 1, 5'd7, 0);
        idle(); #3;
        chk("ld req1", 32'(bus.mem_req),     32'd1);
        chk("ld rdy1", 32'(bus.issue_ready), 32'd0);
        idle(); #3;
        chk("ld req2", 32'(bus.mem_req), 32'd0);
        idle();
        cyc(0, 2'd0, 0, 5'd0, 1); #3;
        chk("ld we",   32'(bus.rf_we),       32'd1);
        chk("ld sel",  32'(bus.wb_sel),      32'd1);
        chk("ld addr", 32'(bus.rf_waddr),    32'd7);
        chk("ld rdy4", 32'(bus.issue_ready), 32'd0);
        idle(); #3;
        chk("ld rdy after", 32'(bus.issue_ready), 32'd1);

        // Load timeout
        cyc(1, 2'd1, 1, 5'd7, 0);
        errs = 0;
        for (int i = 1; i <= TO; i++) begin
            idle(); #3;
            if (i < TO) errs += int'(bus.err);
        end
        chk("to early err", 32'(errs),     32'd0);
        chk("to err",       32'(bus.err),  32'd1);
        chk("to we",        32'(bus.rf_we), 32'd0);
        cyc(0, 2'd0, 0, 5'd0, 1); #3;
        chk("late rsp we", 32'(bus.rf_we), 32'd0);

        // Reserved source and rd=0
        cyc(1, 2'd3, 1, 5'd3, 0);
        cyc(1, 2'd0, 1, 5'd0, 0); #3;
        chk("rsvd err", 32'(bus.err),    32'd1);
        chk("rsvd we",  32'(bus.rf_we),  32'd0);
        chk("rsvd sel", 32'(bus.wb_sel), 32'd0);
        idle(); #3;
        chk("x0 we", 32'(bus.rf_we), 32'd0);

        // Zero-latency load
        cyc(1, 2'd1, 1, 5'd9, 0);
        cyc(0, 2'd0, 0, 5'd0, 1); #3;
        chk("zl req", 32'(bus.mem_req), 32'd1);
        chk("zl we",  32'(bus.rf_we),   32'd1);
        idle();

        // Async reset mid-load
        cyc(1, 2'd1, 1, 5'd4, 0);
        idle(); #3;
        chk("pre-rst req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("async req",   32'(bus.mem_req),     32'd0);
        chk("async rdy",   32'(bus.issue_ready), 32'd1);
        chk("async sel",   32'(bus.wb_sel),      32'd0);
        chk("async waddr", 32'(bus.rf_waddr),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 2'd0, 1, 5'd6, 0);
        idle(); #3;
        chk("post-rst we",   32'(bus.rf_we),    32'd1);
        chk("post-rst addr", 32'(bus.rf_waddr), 32'd6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 399) == 0) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        idle();
        idle(); #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
